// File: rtl/alu_ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ser_pkg
//  Purpose  : Shared types and constants for the ALU result serializer:
//             FSM state encoding, payload widths and a frame-length helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_ser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_FLAGS = 3'd3,
        ST_STOP  = 3'd4
    } alu_ser_state_e;

    localparam int ALU_SER_DATA_BITS = 8;
    localparam int ALU_SER_FLAG_BITS = 4;

    // Frame length in clock cycles: START + payload + STOP bit periods.
    function automatic int alu_ser_frame_len(input int clks_per_bit, input bit flags_en);
        return clks_per_bit * (2 + ALU_SER_DATA_BITS + (flags_en ? ALU_SER_FLAG_BITS : 0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_bit_timer
//  Purpose  : Per-bit cycle counter for the serializer. Counts
//             0..CLKS_PER_BIT-1 while enabled and holds at 0 otherwise.
//  Ports    : clk    - clock
//             reset  - asynchronous active-high reset
//             enable - count while high, clear to 0 while low
//             wrap   - high in the last cycle of a bit period
//             mid    - high in the cycle where cnt == CLKS_PER_BIT/2
//  Revision : 1.0 - initial release
// ============================================================================
module alu_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic wrap,
    output logic mid
);

    localparam logic [7:0] c_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] c_MID  = 8'(CLKS_PER_BIT / 2);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (!enable || (r_cnt == c_LAST)) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Both pulses decode registered count only, so they are glitch-free
    // relative to the enable (which is itself decoded from registered state).
    assign wrap = enable && (r_cnt == c_LAST);
    assign mid  = enable && (r_cnt == c_MID);

endmodule
`default_nettype wire

// File: rtl/alu_result_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_serializer
//  Purpose  : Parallel-in/serial-out transmitter for the ALU result byte and,
//             optionally, the V/C/N/Z flags. Frame: START(0), payload MSB
//             first, STOP(1); mid-bit strobe on payload bits only.
//  Options  : ALU_SER_FLAGS_EN - when defined, 4 flag bits follow the data.
//  Ports    : clk        - clock
//             reset      - asynchronous active-high reset
//             in_valid   - send request
//             in_ready   - high in IDLE only
//             in_result  - 8-bit result to send
//             in_flags   - {V,C,N,Z}, used only with ALU_SER_FLAGS_EN
//             ser_data   - serial line, idles high
//             ser_strobe - one-cycle mid-bit pulse on payload bits
//             busy       - high while a frame is in flight
//             done       - one-cycle pulse in the last STOP cycle
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_serializer
    import alu_ser_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_result,
    input  logic [3:0] in_flags,
    output logic       ser_data,
    output logic       ser_strobe,
    output logic       busy,
    output logic       done
);

`ifdef ALU_SER_FLAGS_EN
    localparam int c_SHIFT_W = ALU_SER_DATA_BITS + ALU_SER_FLAG_BITS;
    logic [c_SHIFT_W-1:0] w_load_word;
    assign w_load_word = {in_result, in_flags};
`else
    localparam int c_SHIFT_W = ALU_SER_DATA_BITS;
    logic [c_SHIFT_W-1:0] w_load_word;
    logic                 w_unused_flags;
    assign w_load_word    = in_result;
    assign w_unused_flags = ^in_flags;
`endif

    localparam logic [2:0] c_DATA_LAST = 3'(ALU_SER_DATA_BITS - 1);
    localparam logic [2:0] c_FLAG_LAST = 3'(ALU_SER_FLAG_BITS - 1);

    alu_ser_state_e       r_state;
    alu_ser_state_e       w_next_state;
    logic [c_SHIFT_W-1:0] r_shift;
    logic [2:0]           r_bit_cnt;
    logic                 w_timer_en;
    logic                 w_wrap;
    logic                 w_mid;
    logic                 w_accept;
    logic                 w_payload;
    logic                 w_bit_last;

    assign w_timer_en = (r_state != ST_IDLE);
    assign w_accept   = in_valid && (r_state == ST_IDLE);
    assign w_payload  = (r_state == ST_DATA) || (r_state == ST_FLAGS);
    assign w_bit_last = (r_state == ST_DATA) ? (r_bit_cnt == c_DATA_LAST)
                                             : (r_bit_cnt == c_FLAG_LAST);

    alu_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (w_timer_en),
        .wrap   (w_wrap),
        .mid    (w_mid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Shift register is loaded once at the handshake, so later input changes
    // cannot disturb the frame in flight. Data and flags share one register,
    // letting the MSB tap feed the line through both payload states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= 3'd0;
        end else if (w_accept) begin
            r_shift   <= w_load_word;
            r_bit_cnt <= 3'd0;
        end else if (w_payload && w_wrap) begin
            r_shift   <= {r_shift[c_SHIFT_W-2:0], 1'b0};
            r_bit_cnt <= w_bit_last ? 3'd0 : (r_bit_cnt + 3'd1);
        end
    end

    // Outputs decode registered state only; in_valid steers next state alone.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        ser_data     = 1'b1;
        ser_strobe   = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                ser_data = 1'b0;
                if (w_wrap) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                ser_data   = r_shift[c_SHIFT_W-1];
                ser_strobe = w_mid;
                if (w_wrap && w_bit_last) begin
`ifdef ALU_SER_FLAGS_EN
                    w_next_state = ST_FLAGS;
`else
                    w_next_state = ST_STOP;
`endif
                end
            end
`ifdef ALU_SER_FLAGS_EN
            ST_FLAGS: begin
                ser_data   = r_shift[c_SHIFT_W-1];
                ser_strobe = w_mid;
                if (w_wrap && w_bit_last) begin
                    w_next_state = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                done = w_wrap;
                if (w_wrap) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/alu_result_serializer.md
# alu_result_serializer

Parallel-in/serial-out transmitter returning the ALU's 8-bit result, and optionally its Z/N/C/V flags, over a single data wire plus a mid-bit strobe. It is the counterpart of the operand shift-in path: its `ser_data`/`ser_strobe` pair drives a bit-serial receiver exactly as `data_in`/`load_bit` drive the operand registers. It sits between the ALU core and the output pins.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range 2..255.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request to send `in_result`/`in_flags`.
- `in_ready`  out  1  high only in IDLE; transfer occurs when `in_valid && in_ready` at a rising edge.
- `in_result`  in  8  ALU result to serialize.
- `in_flags`  in  4  {Overflow, Carry, Negative, Zero}; used only when flags are enabled.
- `ser_data`  out  1  serial line; idles high.
- `ser_strobe`  out  1  one-cycle pulse, mid-bit, on payload bits only.
- `busy`  out  1  high from the cycle after capture through the last STOP cycle.
- `done`  out  1  one-cycle pulse in the final STOP cycle.

## Operation
- States: IDLE -> START -> DATA -> [FLAGS] -> STOP -> IDLE.
- IDLE: `ser_data`=1, `in_ready`=1. On handshake, latch `in_result` and `in_flags` into a shift register and go to START. Later input changes have no effect on the frame in flight.
- START: `ser_data`=0 for one bit period, no strobe.
- DATA: 8 bits, MSB first (`in_result[7]` first). A receiver that shifts left and inserts at the LSB reconstructs the original byte.
- FLAGS (macro only): 4 bits, `in_flags[3]` (V) first, then C, N, Z.
- STOP: `ser_data`=1 for one bit period, no strobe; `done` pulses in its last cycle.
- Bit timer `cnt` counts 0..CLKS_PER_BIT-1 within each bit. `ser_strobe` = (state is DATA or FLAGS) && `cnt` == CLKS_PER_BIT/2 (integer division).
- A bit counter of 0..7 (DATA) or 0..3 (FLAGS) advances when `cnt` wraps. State changes on the wrap of the last bit.
- `in_valid` is ignored while busy; there is no queueing and no error.

## Timing
- Reset values: `ser_data`=1; `ser_strobe`, `busy`, `done`=0; `in_ready`=1; state IDLE; counters 0.
- A handshake at edge 0 makes START visible in cycle 1.
- Frame length is 10·CLKS_PER_BIT cycles, or 14·CLKS_PER_BIT with flags.
- `done` is in cycle N (the frame length). `in_ready` returns in cycle N+1. The minimum handshake-to-handshake spacing is therefore N+1 cycles.
- Reset mid-frame aborts immediately: outputs return to their reset values asynchronously, with no partial `done`.
- All outputs are registered or decoded from registered state only; there are no input-to-output combinational paths.

## Configuration
- `ALU_SER_FLAGS_EN` defined: the FLAGS state exists, the frame is 14 bits, and the strobe count is 12.
- Not defined: the FLAGS state is removed, `in_flags` is unused, the frame is 10 bits, and the strobe count is 8.

## Structure
- Package `alu_ser_pkg` holds:
  - the state enumeration;
  - `ALU_SER_DATA_BITS`=8 and `ALU_SER_FLAG_BITS`=4;
  - a frame-length function of CLKS_PER_BIT and the flag option.
- Sub-module `alu_bit_timer` holds the CLKS_PER_BIT counter. It has an enable input and outputs `wrap` and `mid` pulses.
- The FSM and shift register stay in the top module.

## Test plan
Run with CLKS_PER_BIT=4 unless noted.
- Reset: assert `reset` asynchronously -> `ser_data`=1, `in_ready`=1, `busy`=0.
- Send 0xA5 with no flags (handshake at edge 0):
  - line per bit period: 0,1,0,1,0,0,1,0,1,1;
  - 8 strobes, the first in cycle 7, then every 4 cycles;
  - `done` in cycle 40, `in_ready` high in cycle 41.
- Back-to-back sends of 0xFF then 0x00 with `in_valid` held high:
  - the second capture occurs at edge 41;
  - the strobed bits read 11111111 then 00000000.
- Flags (`ALU_SER_FLAGS_EN`): result 0x80, flags 4'b1010 -> payload 10000000 then 1010, 12 strobes, `done` in cycle 56.
- Reset mid-frame: assert `reset` at cycle 15 of a 0x3C send:
  - `ser_data`=1 at once;
  - no `done`;
  - a fresh 0x3C send afterwards is bit-exact.
- Ignore while busy and CLKS_PER_BIT=2: toggle `in_valid` and change `in_result` during a 0x5A frame -> the frame still carries 0x5A. At CLKS_PER_BIT=2 the strobe falls on the second cycle of each bit.
